// File: rtl/renode_inputs_scheduler.sv
// renode_inputs_scheduler: round-robin sequencer of GPIO input change events toward Renode
module renode_inputs_scheduler #(
    parameter int InputsCount = 32,
    parameter int AddrWidth = (InputsCount > 1) ? $clog2(InputsCount) : 1,
    parameter int CountWidth = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [InputsCount-1:0] inputs,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [AddrWidth-1:0]   evt_addr,
    output logic                   evt_value,
    output logic [InputsCount-1:0] pending,
    output logic                   pending_any,
    output logic [CountWidth-1:0]  evt_count
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t state, state_next;
    logic [InputsCount-1:0] inputs_q, reported;
    logic [AddrWidth-1:0] rr_ptr, winner;
    logic [AddrWidth:0] scan;
    logic found, grant, done;
    assign pending = inputs_q ^ reported;
    assign pending_any = |pending;
    assign grant = (state == IDLE) && enable && pending_any;
    assign done = (state == OFFER) && evt_ready;
    // first pending input at or above rr_ptr, wrapping past the top index
    always_comb begin
        winner = '0;
        found = 1'b0;
        scan = '0;
        for (int i = 0; i < InputsCount; i++) begin
            scan = {1'b0, rr_ptr} + (AddrWidth+1)'(i);
            scan = (scan >= (AddrWidth+1)'(InputsCount)) ? scan - (AddrWidth+1)'(InputsCount) : scan;
            if (!found && pending[scan[AddrWidth-1:0]]) begin
                found = 1'b1;
                winner = scan[AddrWidth-1:0];
            end
        end
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    end
    // offer on a grant, return to idle once the consumer takes the event
    always_comb begin
        state_next = (state == IDLE) ? (grant ? OFFER : IDLE) : (evt_ready ? IDLE : OFFER);
    end
    // an event is on offer exactly while in OFFER
    always_comb begin
        evt_valid = (state == OFFER);
    end
    // sampling, offer capture and bookkeeping on completed handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inputs_q <= '0;
            reported <= '0;
            rr_ptr <= '0;
            evt_addr <= '0;
            evt_value <= 1'b0;
            evt_count <= '0;
        end else begin
            inputs_q <= inputs;
            if (grant) begin
                evt_addr <= winner;
                evt_value <= inputs_q[winner];
            end
            if (done) begin
                reported[evt_addr] <= evt_value;
                evt_count <= evt_count + CountWidth'(1);
                rr_ptr <= (evt_addr == AddrWidth'(InputsCount - 1)) ? '0 : evt_addr + AddrWidth'(1);
            end
        end
    end
endmodule

// File: tb/tb_renode_inputs_scheduler.sv
// tb_renode_inputs_scheduler: directed and randomized checks against a cycle-level reference model
module tb_renode_inputs_scheduler;
    localparam int N = 32;
    localparam int AW = 5;
    localparam int CW = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic evt_ready = 1'b0;
    logic [N-1:0] inputs = '0;
    logic evt_valid, evt_value, pending_any;
    logic [AW-1:0] evt_addr;
    logic [N-1:0] pending;
    logic [CW-1:0] evt_count;
    int n_chk = 0;
    int n_fail = 0;
    logic [N-1:0] m_inq, m_rep;
    bit m_valid, m_val;
    int m_addr, m_ptr, m_cnt;
    logic [AW:0] hs[$];

    renode_inputs_scheduler #(.InputsCount(N), .CountWidth(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .inputs(inputs),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_addr(evt_addr),
        .evt_value(evt_value), .pending(pending), .pending_any(pending_any),
        .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_inq = '0; m_rep = '0; m_valid = 0; m_val = 0; m_addr = 0; m_ptr = 0; m_cnt = 0;
    endtask

    // one clock: log handshakes, advance the model from the spec's rules, compare everything
    task automatic cycle();
        logic [N-1:0] pend;
        int j;
        if (rst_n && evt_valid && evt_ready) hs.push_back({evt_addr, evt_value});
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            pend = m_inq ^ m_rep;
            if (m_valid) begin
                if (evt_ready) begin
                    m_rep[m_addr] = m_val;
                    m_cnt++;
                    m_ptr = (m_addr + 1) % N;
                    m_valid = 0;
                end
            end else if (enable && pend != 0) begin
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (pend[j]) begin
                        m_addr = j; m_val = m_inq[j]; m_valid = 1;
                        break;
                    end
                end
            end
            m_inq = inputs;
        end
        #1;
        chk("valid", evt_valid, m_valid);
        chk("addr", evt_addr, m_addr);
        chk("value", evt_value, m_val);
        chk("pending", pending, m_inq ^ m_rep);
        chk("pending_any", pending_any, |(m_inq ^ m_rep));
        chk("count", evt_count, m_cnt % (1 << CW));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!evt_valid && n < budget) begin
            cycle();
            n++;
        end
        chk("offer_seen", evt_valid, 1);
    endtask

    initial begin
        model_reset();
        run(3);
        chk("reset_valid", evt_valid, 0);
        chk("reset_count", evt_count, 0);
        chk("reset_pending", pending, 0);
        rst_n = 1;
        enable = 1; evt_ready = 1; inputs = 32'h5;
        run(2);
        chk("latency_valid", evt_valid, 1);
        chk("first_addr", evt_addr, 0);
        run(4);
        chk("two_events", evt_count, 2);
        chk("two_pending", pending, 0);
        hs.delete();
        inputs = 32'hF;
        run(6);
        chk("rr_first", (hs.size() > 0) ? hs[0] : 6'h3F, {5'd3, 1'b1});
        chk("rr_second", (hs.size() > 1) ? hs[1] : 6'h3F, {5'd1, 1'b1});
        evt_ready = 0; inputs = 32'h1F;
        cycle();
        wait_valid(10);
        chk("bp_addr", evt_addr, 4);
        inputs = 32'hF;
        run(10);
        chk("bp_hold_valid", evt_valid, 1);
        chk("bp_hold_addr", evt_addr, 4);
        chk("bp_hold_value", evt_value, 1);
        hs.delete();
        evt_ready = 1;
        run(6);
        chk("bp_events", hs.size(), 2);
        chk("bp_second", (hs.size() > 1) ? hs[1] : 6'h3F, {5'd4, 1'b0});
        hs.delete();
        enable = 0; inputs = 32'h8F;
        run(3);
        inputs = 32'hF;
        run(3);
        enable = 1;
        run(6);
        chk("glitch_events", hs.size(), 0);
        chk("glitch_count", evt_count, 6);
        evt_ready = 0; inputs = 32'h20F;
        cycle();
        wait_valid(10);
        #2 rst_n = 0;
        #1;
        chk("async_valid", evt_valid, 0);
        chk("async_count", evt_count, 0);
        chk("async_pending", pending, 0);
        model_reset();
        inputs = '0;
        run(2);
        rst_n = 1; evt_ready = 1;
        hs.delete();
        run(8);
        chk("post_reset_events", hs.size(), 0);
        inputs = 32'h1FFFF;
        run(40);
        chk("wrap_count", evt_count, 1);
        chk("wrap_pending", pending, 0);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) inputs[$urandom_range(0, N-1)] ^= 1'b1;
            enable = ($urandom_range(0, 9) != 0);
            evt_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        enable = 1; evt_ready = 1;
        run(80);
        chk("drained", pending, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
